serial_add_ctrl: RTL

//   Sequencer that time-shares one half-adder pair (two half adders + carry flop = serial full adder)
//   to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.

---
 rtl/serial_add_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder sequencer. One serial full adder (two half adders plus a
// carry flop) adds two WIDTH-bit operands LSB first, one bit per clock, behind
// a start/ready/done handshake.
//
// Timing: a start accepted on edge k puts the block in SHIFT for WIDTH cycles.
// It then spends one cycle in DONE. A start seen in DONE is accepted
// immediately, so back-to-back operations complete every WIDTH+1 cycles.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset; aborts any operation
//   start      in   1      request; accepted only while ready=1
//   a, b       in   WIDTH  operands, sampled on the accepting edge only
//   sub        in   1      (SERIAL_ADD_SUB_EN builds only) 1 = compute a-b
//   ready      out  1      block can accept start (IDLE or DONE)
//   busy       out  1      serial addition in progress (SHIFT)
//   sum        out  WIDTH  result; updated on entry to DONE, held otherwise
//   carry_out  out  1      final carry (no-borrow flag when subtracting)
//   done       out  1      one-cycle pulse: sum/carry_out just updated
//
// Configuration
//   SERIAL_ADD_SUB_EN : when defined, adds the `sub` port. With sub=1, b is
//                       inverted and the carry is preset to 1, giving a+~b+1.
//                       When undefined, the block always adds.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic             sub_in;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] acc_shifted;
  logic             ha0_s, ha0_c, ha1_s, ha1_c;
  logic             bit_sum, bit_carry;
  logic             can_accept;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Operand B is conditionally inverted on the way into its shift register.
  // Together with the preset carry, this turns the adder into a subtractor.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign b_eff[gi] = b[gi] ^ sub_in;
    end
  endgenerate

  // Serial full adder built from two half adders.
  assign ha0_s     = opa_reg[0] ^ opb_reg[0];
  assign ha0_c     = opa_reg[0] & opb_reg[0];
  assign ha1_s     = ha0_s ^ carry_reg;
  assign ha1_c     = ha0_s & carry_reg;
  assign bit_sum   = ha1_s;
  assign bit_carry = ha0_c | ha1_c;

  // New sum bits enter at the MSB. After WIDTH shifts, bit 0 holds the LSB.
  generate
    if (WIDTH == 1) begin : g_acc1
      assign acc_shifted = bit_sum;
    end else begin : g_accn
      assign acc_shifted = {bit_sum, acc_reg[WIDTH-1:1]};
    end
  endgenerate

  assign can_accept = (state_reg == S_IDLE) || (state_reg == S_DONE);

  always_comb begin
    state_next = state_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    acc_next   = acc_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (start) begin
          opa_next   = a;
          opb_next   = b_eff;
          carry_next = sub_in;
          cnt_next   = '0;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        opa_next   = opa_reg >> 1;
        opb_next   = opb_reg >> 1;
        carry_next = bit_carry;
        acc_next   = acc_shifted;
        cnt_next   = cnt_reg + 1'b1;
        // Visible outputs change only here, so they hold the previous
        // result for the whole of SHIFT.
        if (cnt_reg == LAST_CNT) begin
          sum_next   = acc_shifted;
          cout_next  = bit_carry;
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      acc_reg   <= acc_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign ready     = can_accept;
  assign busy      = (state_reg == S_SHIFT);
  assign done      = (state_reg == S_DONE);
  assign sum       = sum_reg;
  assign carry_out = cout_reg;

endmodule
